// File: rtl/sd_req_sched_pkg.sv
// Shared types and constants for the virtual-disk request scheduler.
package apple2_sd_pkg;

  localparam int SD_TIMER_W = 24;

  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_REQ  = 2'd1,
    SCH_XFER = 2'd2
  } sch_state_t;

endpackage

// File: rtl/sd_req_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of pend at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] index
);

  logic [W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest pending one is kept.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(ptr) + k) % N);
      if (pend[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/sd_req_sched.sv
// Arbitrates floppy/HDD block requests onto the hps_io sd_rd/sd_wr channels,
// one transfer at a time, with per-client busy/done/error status.
//
// state    | meaning
// SCH_IDLE | nothing in flight; grant the next pending client round-robin
// SCH_REQ  | sd_rd/sd_wr asserted for gnt, waiting for sd_ack to rise
// SCH_XFER | sd_ack high, buffer strobes routed to gnt until sd_ack falls
module sd_req_sched
  import apple2_sd_pkg::*;
#(
  parameter int                    NUM_REQ     = 3,
  parameter logic [SD_TIMER_W-1:0] ACK_TIMEOUT = 24'hFFFFFF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] cli_rd,
  input  logic [NUM_REQ-1:0] cli_wr,
  output logic [NUM_REQ-1:0] cli_busy,
  output logic [NUM_REQ-1:0] cli_done,
  output logic [NUM_REQ-1:0] cli_err,
  output logic [NUM_REQ-1:0] cli_buff_we,
  output logic [NUM_REQ-1:0] sd_rd,
  output logic [NUM_REQ-1:0] sd_wr,
  input  logic [NUM_REQ-1:0] sd_ack,
  input  logic               sd_buff_wr
);

  localparam int                    PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SD_TIMER_W-1:0] TMO_LAST = ACK_TIMEOUT - 1'b1;
  localparam logic [PTR_W-1:0]      LAST_IDX = PTR_W'(NUM_REQ - 1);

  sch_state_t              state;
  logic [NUM_REQ-1:0]      pend_rd;
  logic [NUM_REQ-1:0]      pend_wr;
  logic [NUM_REQ-1:0]      pend_any;
  logic [NUM_REQ-1:0]      ack_q;
  logic [NUM_REQ-1:0]      gnt_oh;
  logic [NUM_REQ-1:0]      pick_oh;
  logic [NUM_REQ-1:0]      clr_rd;
  logic [NUM_REQ-1:0]      clr_wr;
  logic [PTR_W-1:0]        gnt;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        pick_idx;
  logic [PTR_W-1:0]        nxt_ptr;
  logic [SD_TIMER_W-1:0]   timer;
  logic                    pick_valid;
  logic                    op_wr;
  logic                    ack_rise;
  logic                    ack_fall;
  logic                    tmo_hit;

  assign pend_any = pend_rd | pend_wr;

  rr_pick #(
    .N (NUM_REQ),
    .W (PTR_W)
  ) u_pick (
    .pend  (pend_any),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign gnt_oh   = NUM_REQ'(1) << gnt;
  assign pick_oh  = NUM_REQ'(1) << pick_idx;
  assign ack_rise = sd_ack[gnt] & ~ack_q[gnt];
  assign ack_fall = ~sd_ack[gnt] & ack_q[gnt];
  assign tmo_hit  = (ACK_TIMEOUT != '0) && (timer == TMO_LAST);
  assign nxt_ptr  = (gnt == LAST_IDX) ? '0 : gnt + 1'b1;

  // The op's pending bit goes away when hps_io accepts it or when we give up on it.
  always_comb begin
    clr_rd = '0;
    clr_wr = '0;
    if (state == SCH_REQ && (ack_rise || tmo_hit)) begin
      if (op_wr) clr_wr = gnt_oh;
      else       clr_rd = gnt_oh;
    end
  end

  assign cli_busy    = pend_any | ((state != SCH_IDLE) ? gnt_oh : '0);
  assign cli_buff_we = (state == SCH_XFER && sd_buff_wr && sd_ack[gnt]) ? gnt_oh : '0;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= SCH_IDLE;
      pend_rd  <= '0;
      pend_wr  <= '0;
      ack_q    <= '0;
      gnt      <= '0;
      rr_ptr   <= '0;
      op_wr    <= 1'b0;
      timer    <= '0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      cli_done <= '0;
      cli_err  <= '0;
    end else begin
      ack_q    <= sd_ack;
      cli_done <= '0;
      cli_err  <= '0;
      // A new pulse overrides a clear in the same cycle.
      pend_rd  <= (pend_rd & ~clr_rd) | cli_rd;
      pend_wr  <= (pend_wr & ~clr_wr) | cli_wr;

      case (state)
        SCH_IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_idx;
            op_wr <= ~pend_rd[pick_idx];
            if (pend_rd[pick_idx]) sd_rd <= pick_oh;
            else                   sd_wr <= pick_oh;
            timer <= '0;
            state <= SCH_REQ;
          end
        end
        SCH_REQ: begin
          if (ack_rise) begin
            sd_rd <= '0;
            sd_wr <= '0;
            state <= SCH_XFER;
          end else if (tmo_hit) begin
            sd_rd   <= '0;
            sd_wr   <= '0;
            cli_err <= gnt_oh;
            rr_ptr  <= nxt_ptr;
            state   <= SCH_IDLE;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        SCH_XFER: begin
          if (ack_fall) begin
            cli_done <= gnt_oh;
            rr_ptr   <= nxt_ptr;
            state    <= SCH_IDLE;
          end
        end
        default: state <= SCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_req_sched.sv
// Randomized bench for sd_req_sched: a reactive hps_io responder plus a
// transaction-level reference model of the scheduling rules.
module tb_sd_req_sched;

  localparam int N   = 3;
  localparam int TMO = 16;
  localparam int NCYC = 6000;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_DATA = 2;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic [N-1:0] cli_rd, cli_wr, cli_busy, cli_done, cli_err, cli_buff_we;
  logic [N-1:0] sd_rd, sd_wr, sd_ack;
  logic         sd_buff_wr;

  always #5 clk_sys = ~clk_sys;

  sd_req_sched #(
    .NUM_REQ     (N),
    .ACK_TIMEOUT (24'd16)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .cli_rd      (cli_rd),
    .cli_wr      (cli_wr),
    .cli_busy    (cli_busy),
    .cli_done    (cli_done),
    .cli_err     (cli_err),
    .cli_buff_we (cli_buff_we),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] oh(input int c);
    return N'(1 << c);
  endfunction

  // Reference model: pending sets, current grant, rotation pointer, wait count.
  int           m_mode, m_cur, m_rr, m_wait;
  logic         m_cur_wr;
  logic [N-1:0] m_prd, m_pwr, m_prev, m_done, m_err;
  int           n_done_model = 0, n_err_model = 0;
  int           n_done_dut = 0, n_err_dut = 0;

  task automatic model_edge(input logic [N-1:0] rd, input logic [N-1:0] wr,
                            input logic [N-1:0] ack, input logic rst);
    logic [N-1:0] crd, cwr;
    int c;
    m_done = '0;
    m_err  = '0;
    crd    = '0;
    cwr    = '0;
    if (rst) begin
      m_mode = M_IDLE; m_cur = 0; m_cur_wr = 1'b0; m_rr = 0; m_wait = 0;
      m_prd = '0; m_pwr = '0; m_prev = '0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if ((m_prd | m_pwr) != '0) begin
          for (int k = N - 1; k >= 0; k--) begin
            c = (m_rr + k) % N;
            if (((m_prd | m_pwr) & oh(c)) != '0) m_cur = c;
          end
          m_cur_wr = ((m_prd & oh(m_cur)) == '0);
          m_mode   = M_WAIT;
          m_wait   = 0;
        end
      end
      M_WAIT: begin
        if ((ack & oh(m_cur)) != '0 && (m_prev & oh(m_cur)) == '0) begin
          if (m_cur_wr) cwr = oh(m_cur); else crd = oh(m_cur);
          m_mode = M_DATA;
        end else if (m_wait == TMO - 1) begin
          if (m_cur_wr) cwr = oh(m_cur); else crd = oh(m_cur);
          m_err  = oh(m_cur);
          m_rr   = (m_cur + 1) % N;
          m_mode = M_IDLE;
          n_err_model++;
        end else begin
          m_wait++;
        end
      end
      default: begin
        if ((ack & oh(m_cur)) == '0 && (m_prev & oh(m_cur)) != '0) begin
          m_done = oh(m_cur);
          m_rr   = (m_cur + 1) % N;
          m_mode = M_IDLE;
          n_done_model++;
        end
      end
    endcase
    m_prd  = (m_prd & ~crd) | rd;
    m_pwr  = (m_pwr & ~cwr) | wr;
    m_prev = ack;
  endtask

  // Responder (hps_io stand-in) state
  int           r_state = 0, r_cli = 0, r_cnt = 0;
  logic         mid_rst_done = 1'b0;

  initial begin
    logic [N-1:0] exp_rd, exp_wr, exp_busy, exp_we, req, ack_n, rd_n, wr_n;
    logic         rst_now, bwr_n;

    reset = 1'b1; cli_rd = '0; cli_wr = '0; sd_ack = '0; sd_buff_wr = 1'b0;
    model_edge('0, '0, '0, 1'b1);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk_sys);
      #1;
      exp_rd   = (m_mode == M_WAIT && !m_cur_wr) ? oh(m_cur) : '0;
      exp_wr   = (m_mode == M_WAIT &&  m_cur_wr) ? oh(m_cur) : '0;
      exp_busy = m_prd | m_pwr | ((m_mode != M_IDLE) ? oh(m_cur) : '0);
      check("sd_rd",    32'(sd_rd),    32'(exp_rd));
      check("sd_wr",    32'(sd_wr),    32'(exp_wr));
      check("cli_busy", 32'(cli_busy), 32'(exp_busy));
      check("cli_done", 32'(cli_done), 32'(m_done));
      check("cli_err",  32'(cli_err),  32'(m_err));
      if (cli_done != '0) n_done_dut++;
      if (cli_err  != '0) n_err_dut++;

      rst_now = (cyc < 3) || ($urandom_range(0, 699) == 0);
      if (!mid_rst_done && cyc > 2000 && m_mode == M_DATA) begin
        rst_now      = 1'b1;
        mid_rst_done = 1'b1;
      end

      req   = sd_rd | sd_wr;
      ack_n = '0;
      bwr_n = 1'b0;
      rd_n  = '0;
      wr_n  = '0;
      if (rst_now) begin
        ack_n   = sd_ack;
        r_state = 0;
      end else begin
        case (r_state)
          0: begin
            if (req != '0) begin
              for (int i = 0; i < N; i++) if ((req & oh(i)) != '0) r_cli = i;
              r_cnt   = $urandom_range(1, 20);
              r_state = 1;
            end
          end
          1: begin
            if (req == '0) begin
              r_state = 0;
            end else begin
              r_cnt--;
              if (r_cnt == 0) begin
                ack_n   = oh(r_cli);
                r_cnt   = $urandom_range(1, 12);
                r_state = 2;
              end
            end
          end
          default: begin
            r_cnt--;
            if (r_cnt == 0) begin
              r_state = 0;
            end else begin
              ack_n = oh(r_cli);
              bwr_n = ($urandom_range(0, 1) == 1);
            end
          end
        endcase
        if (r_state != 0)
          for (int i = 0; i < N; i++)
            if (i != r_cli && $urandom_range(0, 3) == 0) ack_n |= oh(i);
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 15) == 0) rd_n |= oh(i);
          if ($urandom_range(0, 15) == 0) wr_n |= oh(i);
        end
        if (cyc % 500 == 100) rd_n = '1;
      end

      reset      = rst_now;
      cli_rd     = rd_n;
      cli_wr     = wr_n;
      sd_ack     = ack_n;
      sd_buff_wr = bwr_n;
      #1;
      exp_we = (m_mode == M_DATA && bwr_n && (ack_n & oh(m_cur)) != '0) ? oh(m_cur) : '0;
      check("cli_buff_we", 32'(cli_buff_we), 32'(exp_we));
      model_edge(rd_n, wr_n, ack_n, rst_now);
    end

    check("done_total", 32'(n_done_dut), 32'(n_done_model));
    check("err_total",  32'(n_err_dut),  32'(n_err_model));
    check("done_seen",  32'(n_done_dut > 10), 32'(1));
    check("err_seen",   32'(n_err_dut > 0),    32'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
